// File: rtl/ch_gate_seq.sv
// ---------------------------------------------------------------------------
// ch_gate_seq
// Clock-gating and reset sequencer for the SCA channel array. Each channel
// runs its own four-state sequencer. The sequencer holds the channel reset for
// a fixed number of gated-clock edges after wake-up and again before the clock
// is gated off. When STAGGER=1, at most one channel can leave OFF per cycle,
// which limits the inrush current.
//
// Ports
//   clk        in   global clock
//   resetB     in   asynchronous active-low reset
//   ch_enable  in   [N_CH] per-channel enable request (level, clk-synchronous)
//   ch_clk     out  [N_CH] glitch-free gated channel clock
//   ch_res     out  [N_CH] channel reset, active high, changes on negedge clk
//   ch_ready   out  [N_CH] channel is in RUN
//   busy       out  any channel sequencing, or requesting while OFF
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_OFF   | clock gated, reset held, waiting for enable + grant
// S_WAKE  | clock running, reset held for RST_CYC edges
// S_RUN   | clock running, reset released
// S_SLEEP | clock running, reset held for DIS_CYC edges, then gate off
// ---------------------------------------------------------------------------
module ch_gate_seq #(
  parameter int N_CH    = 22,
  parameter int RST_CYC = 2,
  parameter int DIS_CYC = 2,
  parameter int STAGGER = 1
) (
  input  logic            clk,
  input  logic            resetB,
  input  logic [N_CH-1:0] ch_enable,
  output logic [N_CH-1:0] ch_clk,
  output logic [N_CH-1:0] ch_res,
  output logic [N_CH-1:0] ch_ready,
  output logic            busy
);

  localparam int CNT_MAX = (RST_CYC > DIS_CYC) ? RST_CYC : DIS_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] DIS_LAST = CW'(DIS_CYC - 1);
  localparam logic [N_CH-1:0] ONE    = {{(N_CH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_WAKE  = 2'd1,
    S_RUN   = 2'd2,
    S_SLEEP = 2'd3
  } state_e;

  state_e          state_q [N_CH];
  state_e          state_d [N_CH];
  logic [CW-1:0]   cnt_q   [N_CH];
  logic [CW-1:0]   cnt_d   [N_CH];

  logic [N_CH-1:0] req;
  logic [N_CH-1:0] grant;
  logic [N_CH-1:0] en;
  logic [N_CH-1:0] en_lat_q;
  logic [N_CH-1:0] res_d;
  logic [N_CH-1:0] res_q;
  logic [N_CH-1:0] busy_v;

  // Wake-up arbitration. When STAGGER=1, only the lowest set bit of req is
  // granted (req & -req).
  always_comb begin
    req   = '0;
    grant = '0;
    for (int i = 0; i < N_CH; i++) begin
      req[i] = (state_q[i] == S_OFF) && ch_enable[i];
    end
    if (STAGGER != 0) grant = req & (~req + ONE);
    else              grant = req;
  end

  always_comb begin
    en       = '0;
    res_d    = '1;
    ch_ready = '0;
    busy_v   = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        S_OFF: begin
          if (grant[i]) begin
            state_d[i] = S_WAKE;
            cnt_d[i]   = '0;
          end
        end
        S_WAKE: begin
          if (!ch_enable[i]) begin
            state_d[i] = S_SLEEP;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == RST_LAST) begin
            state_d[i] = S_RUN;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        S_RUN: begin
          if (!ch_enable[i]) begin
            state_d[i] = S_SLEEP;
            cnt_d[i]   = '0;
          end
        end
        S_SLEEP: begin
          // SLEEP always runs to completion, so that the DIS_CYC reset edges
          // are delivered even if the enable comes back.
          if (cnt_q[i] == DIS_LAST) begin
            state_d[i] = S_OFF;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = S_OFF;
          cnt_d[i]   = '0;
        end
      endcase
      en[i]       = (state_q[i] != S_OFF);
      res_d[i]    = (state_q[i] != S_RUN);
      ch_ready[i] = (state_q[i] == S_RUN);
      busy_v[i]   = (state_q[i] == S_WAKE) || (state_q[i] == S_SLEEP) || req[i];
    end
  end

  // busy is gated by resetB so that it reads 0 while reset is held, even if
  // ch_enable is high.
  assign busy = resetB & (|busy_v);

  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= S_OFF;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Classic latch-based clock gate. The latch is closed while clk is high, so
  // en can change only while the gated clock is already low. This prevents
  // glitches and runt pulses.
  always_latch begin
    if (!resetB)  en_lat_q <= '0;
    else if (!clk) en_lat_q <= en;
  end

  assign ch_clk = {N_CH{clk}} & en_lat_q;

  // ch_res is updated on the falling edge, so it is stable at every gated
  // rising edge.
  always_ff @(negedge clk or negedge resetB) begin
    if (!resetB) res_q <= '1;
    else         res_q <= res_d;
  end

  assign ch_res = res_q;

endmodule

// File: tb/tb_ch_gate_seq.sv
module tb_ch_gate_seq;

  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          resetB;
  logic [NC-1:0] ch_enable;
  logic [NC-1:0] ch_clk, ch_res, ch_ready;
  logic          busy;
  logic [NC-1:0] ch_clk_s0, ch_res_s0, ch_ready_s0;
  logic          busy_s0;

  ch_gate_seq #(.N_CH(NC), .RST_CYC(3), .DIS_CYC(2), .STAGGER(1)) dut (
    .clk(clk), .resetB(resetB), .ch_enable(ch_enable),
    .ch_clk(ch_clk), .ch_res(ch_res), .ch_ready(ch_ready), .busy(busy)
  );

  ch_gate_seq #(.N_CH(NC), .RST_CYC(3), .DIS_CYC(2), .STAGGER(0)) dut_s0 (
    .clk(clk), .resetB(resetB), .ch_enable(ch_enable),
    .ch_clk(ch_clk_s0), .ch_res(ch_res_s0), .ch_ready(ch_ready_s0), .busy(busy_s0)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Gated-clock edge monitor: counts rising edges, and rising edges that see
  // ch_res high, for each channel. It also records any high pulse shorter
  // than half a clk period, except pulses cut short by reset.
  logic [NC-1:0] prev_clk = '0;
  int            e_cnt [NC];
  int            r_cnt [NC];
  time           t_rise [NC];
  int            runts = 0;

  always @(ch_clk) begin
    for (int i = 0; i < NC; i++) begin
      if (ch_clk[i] && !prev_clk[i]) begin
        e_cnt[i]++;
        if (ch_res[i]) r_cnt[i]++;
        t_rise[i] = $time;
      end else if (!ch_clk[i] && prev_clk[i]) begin
        if (resetB && (($time - t_rise[i]) < 5)) runts++;
      end
    end
    prev_clk = ch_clk;
  end

  int be, br;

  initial begin
    resetB    = 1'b1;
    ch_enable = '0;
    #2 resetB = 1'b0;
    tick(); tick();
    chk("rst_res",      ch_res,    4'hF);
    chk("rst_ready",    ch_ready,  4'h0);
    chk("rst_busy",     busy,      1'b0);
    chk("rst_clk",      ch_clk,    4'h0);
    chk("rst_clk_s0",   ch_clk_s0, 4'h0);
    @(negedge clk); #1 resetB = 1'b1;
    tick(); tick();
    chk("idle_busy",    busy,      1'b0);
    chk("idle_res",     ch_res,    4'hF);

    // 1: wake timing on ch0
    be = e_cnt[0]; br = r_cnt[0];
    ch_enable = 4'b0001;
    tick();
    chk("t1_busy",      busy,      1'b1);
    chk("t1_clk_p0",    ch_clk[0], 1'b0);
    tick();
    chk("t1_clk_p1",    ch_clk[0], 1'b1);
    chk("t1_rdy_p1",    ch_ready,  4'h0);
    tick(); tick();
    chk("t1_ready",     ch_ready,  4'b0001);
    chk("t1_res_hold",  ch_res[0], 1'b1);
    @(negedge clk); #1;
    chk("t1_res_rel",   ch_res[0], 1'b0);
    chk("t1_edges",     e_cnt[0] - be, 3);
    chk("t1_res_edges", r_cnt[0] - br, 3);
    tick(); tick();

    // 2: disable timing on ch0
    ch_enable = 4'b0000;
    tick();
    be = e_cnt[0]; br = r_cnt[0];
    chk("t2_ready",     ch_ready,  4'h0);
    chk("t2_busy",      busy,      1'b1);
    chk("t2_res_pre",   ch_res[0], 1'b0);
    @(negedge clk); #1;
    chk("t2_res_rise",  ch_res[0], 1'b1);
    tick(); tick();
    chk("t2_busy_end",  busy,      1'b0);
    chk("t2_last_edge", ch_clk[0], 1'b1);
    tick(); tick();
    chk("t2_gated",     ch_clk[0], 1'b0);
    chk("t2_edges",     e_cnt[0] - be, 2);
    chk("t2_res_edges", r_cnt[0] - br, 2);

    // 3: stagger vs. simultaneous wake
    ch_enable = 4'b1111;
    tick();
    chk("t3_clk_s",     ch_clk,      4'b0000);
    tick();
    chk("t3_clk_s1",    ch_clk,      4'b0001);
    chk("t3_s0_clk_s1", ch_clk_s0,   4'b1111);
    tick();
    chk("t3_clk_s2",    ch_clk,      4'b0011);
    chk("t3_s0_rdy_s2", ch_ready_s0, 4'b0000);
    tick();
    chk("t3_rdy_s3",    ch_ready,    4'b0001);
    chk("t3_s0_rdy_s3", ch_ready_s0, 4'b1111);
    tick();
    chk("t3_rdy_s4",    ch_ready,    4'b0011);
    tick();
    chk("t3_rdy_s5",    ch_ready,    4'b0111);
    tick();
    chk("t3_rdy_s6",    ch_ready,    4'b1111);
    ch_enable = 4'b0000;
    repeat (4) tick();
    chk("t3_off_busy",  busy,        1'b0);
    chk("t3_off_busy0", busy_s0,     1'b0);

    // 4: abort during WAKE on ch1
    be = e_cnt[1]; br = r_cnt[1];
    ch_enable = 4'b0010;
    tick();
    ch_enable = 4'b0000;
    tick();
    chk("t4_rdy_a1",    ch_ready[1], 1'b0);
    chk("t4_res_a1",    ch_res[1],   1'b1);
    tick();
    chk("t4_busy_a2",   busy,        1'b1);
    chk("t4_res_a2",    ch_res[1],   1'b1);
    tick();
    chk("t4_busy_a3",   busy,        1'b0);
    chk("t4_rdy_a3",    ch_ready[1], 1'b0);
    chk("t4_edges",     e_cnt[1] - be, 3);
    chk("t4_res_edges", r_cnt[1] - br, 3);
    tick();
    chk("t4_gated",     ch_clk[1],   1'b0);

    // 5: re-enable during SLEEP on ch2
    ch_enable = 4'b0100;
    repeat (4) tick();
    chk("t5_run",       ch_ready,    4'b0100);
    ch_enable = 4'b0000;
    tick();
    be = e_cnt[2]; br = r_cnt[2];
    ch_enable = 4'b0100;
    tick();
    chk("t5_rdy_c1",    ch_ready[2], 1'b0);
    tick();
    chk("t5_busy_c2",   busy,        1'b1);
    chk("t5_last_edge", ch_clk[2],   1'b1);
    tick();
    chk("t5_gap",       ch_clk[2],   1'b0);
    chk("t5_edges",     e_cnt[2] - be, 2);
    chk("t5_res_edges", r_cnt[2] - br, 2);
    tick();
    chk("t5_rewake",    ch_clk[2],   1'b1);
    tick();
    chk("t5_rdy_c5",    ch_ready[2], 1'b0);
    tick();
    chk("t5_rdy_c6",    ch_ready,    4'b0100);

    // 6: async reset while in RUN, asserted and released during the clk high phase
    @(posedge clk); #2;
    resetB = 1'b0;
    #1;
    chk("t6_clk",       ch_clk,      4'h0);
    chk("t6_res",       ch_res,      4'hF);
    chk("t6_ready",     ch_ready,    4'h0);
    chk("t6_busy",      busy,        1'b0);
    @(posedge clk); #2;
    resetB = 1'b1;
    #1;
    chk("t6_clk_rel",   ch_clk,      4'h0);
    tick();
    chk("t6_clk_r0",    ch_clk[2],   1'b0);
    chk("t6_rdy_r0",    ch_ready,    4'h0);
    tick();
    chk("t6_clk_r1",    ch_clk[2],   1'b1);
    tick(); tick();
    chk("t6_rdy_r3",    ch_ready,    4'b0100);
    ch_enable = 4'b0000;
    repeat (4) tick();
    chk("final_busy",   busy,        1'b0);
    chk("runts",        runts,       0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ch_gate_seq.md
Name: ch_gate_seq

Overview:
- Parametrised per-channel clock-gating and reset sequencer for the SCA channel array, single clock domain.
- Each channel has its own four-state sequencer, so the number of reset-held clock cycles on enable and on disable is configurable.
- Optional staggering limits how many channels can wake in the same cycle, to bound current surges.
- Outputs a glitch-free gated clock, a channel reset and a ready flag per channel, plus a global busy flag.

Parameters:
- N_CH, 22: number of channels.
- RST_CYC, 2: gated-clock rising edges delivered with ch_res asserted before release on enable. Must be >= 1.
- DIS_CYC, 2: gated-clock rising edges delivered with ch_res asserted before the clock is gated off on disable. Must be >= 1.
- STAGGER, 1: 1 = at most one channel leaves OFF per cycle, lowest index has priority. 0 = all requesting channels leave OFF together.

Ports:
- clk  in  1  global clock.
- resetB  in  1  asynchronous active-low reset.
- ch_enable  in  N_CH  per-channel enable request, level sensitive, synchronous to clk.
- ch_clk  out  N_CH  gated channel clock.
- ch_res  out  N_CH  channel reset, active high.
- ch_ready  out  N_CH  channel in RUN state.
- busy  out  1  any channel in WAKE or SLEEP, or any channel with ch_enable=1 while in OFF.

Behaviour:
- Reset values:
  - resetB low forces every channel to OFF, counters to 0, ch_res to all 1s, ch_ready to 0, busy to 0.
  - The clock-enable latches are forced to 0 asynchronously, so ch_clk is 0 while resetB is low.
  - Reset asserted mid-sequence aborts the sequence immediately. No clock pulses are produced.
- Per-channel FSM, state and counter updated on posedge clk. Counter width is clog2(max(RST_CYC,DIS_CYC)+1).
  - OFF: clock gated. If ch_enable=1 and the channel is granted, go to WAKE with cnt=0. Otherwise stay.
  - WAKE: clock running, reset held.
    - If ch_enable=0, go to SLEEP with cnt=0. This takes priority.
    - Else if cnt==RST_CYC-1, go to RUN.
    - Else cnt increments.
  - RUN: clock running, reset released. If ch_enable=0, go to SLEEP with cnt=0.
  - SLEEP: clock running, reset held.
    - If cnt==DIS_CYC-1, go to OFF. Else cnt increments.
    - SLEEP always completes; ch_enable=1 does not abort it. If ch_enable is still 1 on return to OFF, a new WAKE follows, subject to grant.
- Grant:
  - STAGGER=0: every channel is granted.
  - STAGGER=1: a one-hot grant goes to the lowest-index channel that is in OFF with ch_enable=1. Channels in other states are unaffected.
- Clock gating:
  - en = (state != OFF).
  - en is captured in a latch that is transparent while clk is low.
  - ch_clk = clk AND latched en.
  - No clock glitch and no runt pulse are allowed.
  - The first ch_clk rising edge is the posedge after entry to WAKE. The last is the posedge at which SLEEP exits to OFF.
- ch_res:
  - Registered on negedge clk as (state != RUN), with asynchronous set on resetB low.
  - It is therefore stable at every ch_clk rising edge.
  - Exactly RST_CYC ch_clk rising edges occur with ch_res=1 before RUN.
  - Exactly DIS_CYC ch_clk rising edges occur with ch_res=1 after leaving RUN.
- ch_ready = (state == RUN), decoded from registered state with no further delay.
- busy is combinational from registered state and ch_enable.

Test Plan:
1. Wake timing. N_CH=4, RST_CYC=3, DIS_CYC=2, STAGGER=1. ch_enable[0]=1 sampled at posedge 10.
   - WAKE after posedge 10.
   - ch_clk[0] rises at posedges 11, 12 and 13 with ch_res[0]=1.
   - RUN and ch_ready[0]=1 after posedge 13.
   - ch_res[0] falls at the negedge between 13 and 14.
2. Disable timing. Same configuration, ch_enable[0]=0 sampled at posedge 20.
   - ch_ready[0]=0 after posedge 20.
   - ch_res[0] rises at the following negedge.
   - ch_clk[0] rises at posedges 21 and 22 only, then stays 0.
   - busy=0 after posedge 22.
3. Stagger. ch_enable=4'b1111 sampled at posedge 30.
   - ch0 through ch3 enter WAKE after posedges 30, 31, 32 and 33 respectively.
   - With STAGGER=0, all four enter WAKE after posedge 30.
4. Abort in WAKE. ch_enable[1] set at posedge 40 and cleared at posedge 41.
   - SLEEP after posedge 41.
   - ch_ready[1] never rises.
   - ch_res[1] stays 1 throughout.
   - OFF after posedge 43.
5. Re-enable during SLEEP. ch_enable[2] drops then rises one cycle later.
   - SLEEP completes its DIS_CYC edges.
   - OFF for one posedge, then WAKE.
   - Between SLEEP and the new WAKE there is at least one clk cycle with no ch_clk[2] pulse.
6. Asynchronous reset mid-RUN. resetB low at mid-high phase of clk.
   - ch_clk is 0 at once. ch_res=4'b1111 and ch_ready=0 immediately.
   - After resetB is released, nothing happens until ch_enable is resampled. Checker flags any ch_clk pulse shorter than half a clk period.
